reg_bus_read_sequencer: RTL

- Downstream consumer of the bank of tri-stateable memory/LUI registers that share one read bus.
- Each register drives the bus only while its chip-select is low; the bus floats when chip-select is high.
- This block arbitrates read requests round-robin and drives exactly one register's chip-select low at a time.
- It samples the shared bus after a settle cycle and presents the captured word on a valid/ready output port.

---
 rtl/reg_bus_read_sequencer_pkg.sv | 25 ++
 rtl/reg_bus_read_sequencer_rr_priority_pick.sv | 31 +++
 rtl/reg_bus_read_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/reg_bus_read_sequencer_pkg.sv
// Shared definitions for the register read bus sequencer and the register bank
// that drives the shared tri-state read bus.
package reg_bus_read_sequencer_pkg;

    localparam int DefNrOfRegs = 4;
    localparam int DefNrOfBits = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    // ceil(log2(n)), with a minimum of 1 bit
    function automatic int id_bits(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 16; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/reg_bus_read_sequencer_rr_priority_pick.sv
// Round-robin picker: first set request bit strictly above i_last, wrapping
// around to bit 0. Only indices below NrOfRegs can ever be granted.
module rr_priority_pick #(
    parameter int NrOfRegs = 4,
    parameter int IdBits   = 2
) (
    input  logic [NrOfRegs-1:0] i_req,
    input  logic [IdBits-1:0]   i_last,
    output logic [IdBits-1:0]   o_gnt,
    output logic                o_gnt_valid
);

    always_comb begin
        o_gnt       = '0;
        o_gnt_valid = 1'b0;
        // Upper half first (after the pointer), then the wrapped lower half.
        for (int i = 0; i < NrOfRegs; i++) begin
            if (!o_gnt_valid && i_req[i] && (i > int'(i_last))) begin
                o_gnt       = IdBits'(i);
                o_gnt_valid = 1'b1;
            end
        end
        for (int i = 0; i < NrOfRegs; i++) begin
            if (!o_gnt_valid && i_req[i] && (i <= int'(i_last))) begin
                o_gnt       = IdBits'(i);
                o_gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bus_read_sequencer.sv
// Round-robin read sequencer for a bank of tri-state registers sharing one bus:
// selects one register, lets the bus settle a cycle, captures, then hands off.
module reg_bus_read_sequencer
    import reg_bus_read_sequencer_pkg::*;
#(
    parameter int NrOfRegs = DefNrOfRegs,
    parameter int NrOfBits = DefNrOfBits,
    parameter int IdBits   = id_bits(NrOfRegs)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic [NrOfRegs-1:0] req,
    input  logic [NrOfBits-1:0] bus_in,
    output logic [NrOfRegs-1:0] sel_n,
    output logic [NrOfBits-1:0] rd_data,
    output logic [IdBits-1:0]   rd_id,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                busy
);

    localparam logic [NrOfRegs-1:0] OneHot0 = NrOfRegs'(1);

    state_t                r_state;
    state_t                w_next;
    logic [IdBits-1:0]     r_gnt;
    logic [IdBits-1:0]     r_last;
    logic [NrOfBits-1:0]   r_rd_data;
    logic [IdBits-1:0]     r_rd_id;
    logic [IdBits-1:0]     w_pick;
    logic                  w_pick_vld;
    logic                  w_grant;
    logic                  w_capture;
    logic                  w_drive;

    rr_priority_pick #(
        .NrOfRegs (NrOfRegs),
        .IdBits   (IdBits)
    ) u_pick (
        .i_req       (req),
        .i_last      (r_last),
        .o_gnt       (w_pick),
        .o_gnt_valid (w_pick_vld)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Output handshake deliberately ignores Tick so the consumer is never stalled.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (Tick && w_pick_vld) w_next = ST_DRIVE;
            ST_DRIVE:  if (Tick) w_next = ST_SAMPLE;
            ST_SAMPLE: if (Tick) w_next = ST_OUT;
            ST_OUT:    if (rd_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign w_grant   = (r_state == ST_IDLE) && Tick && w_pick_vld;
    assign w_capture = (r_state == ST_SAMPLE) && Tick;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_gnt     <= '0;
            r_last    <= IdBits'(NrOfRegs - 1);
            r_rd_data <= '0;
            r_rd_id   <= '0;
        end else begin
            if (w_grant) begin
                r_gnt  <= w_pick;
                r_last <= w_pick;
            end
            if (w_capture) begin
                r_rd_data <= bus_in;
                r_rd_id   <= r_gnt;
            end
        end
    end

    // Selects decode straight from state, so an async reset releases the bus at once.
    assign w_drive  = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
    assign sel_n    = w_drive ? ~(OneHot0 << r_gnt) : '1;
    assign rd_data  = r_rd_data;
    assign rd_id    = r_rd_id;
    assign rd_valid = (r_state == ST_OUT);
    assign busy     = (r_state != ST_IDLE);

    always_ff @(posedge Clock) begin
        if (!Reset) assert ($countones(~sel_n) <= 1);
    end

endmodule
